delta_gauss: RTL
================

DELTA_GAUSS -- requirements
Module: delta_gauss

Interface
REQ-001 Parameters SHALL be: PIXELS_PER_BEAT, default 16, pixels per beat; IMAGE_DIM, default 512, square frame side in pixels; DATA_WIDTH, default 8*PIXELS_PER_BEAT, beat width; GAIN_SHIFT, default 2, difference gain (used only under DELTA_GAUSS_GAIN_EN).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- stall  in  1  global hold; 1 freezes all state
- in_valid  in  1  input beat present
- old_frame  in  DATA_WIDTH  previous fused frame beat, pixel j at [8j+:8]
- new_frame  in  DATA_WIDTH  incoming frame beat, same packing
- out_valid  out  1  output beat valid
- old_frame_d  out  DATA_WIDTH  old_frame aligned to del_gauss
- new_frame_d  out  DATA_WIDTH  new_frame aligned to del_gauss
- del_gauss  out  DATA_WIDTH  per-pixel smoothed motion weight, 0..255
- frame_end  out  1  high with the last output beat of a frame

Function
REQ-003 Beat accepted SHALL mean in_valid=1 and stall=0 on a rising edge.
REQ-004 With stall=1, every register SHALL hold and inputs SHALL be ignored.
REQ-005 Per pixel, d = |new - old| as 8-bit unsigned (absolute value, no wrap).
REQ-006 Smoothing SHALL be horizontal [1 2 1]: g = (L + 2C + R + 2) >> 2, 10-bit intermediate, 8-bit result.
REQ-007 L/R for interior pixels SHALL come from the same beat; for pixel 0 L = last d of the previous beat in the same row; for pixel PIXELS_PER_BEAT-1 R = first d of the next beat in the same row.
REQ-008 At row start L = C; at row end R = C (edge replicate).
REQ-009 Counters: column beat 0..IMAGE_DIM/PIXELS_PER_BEAT-1, row 0..IMAGE_DIM-1, advanced on acceptance, both wrapping to 0 after the frame's last beat.
REQ-010 FSM states: EMPTY (nothing held), HOLD (one beat's d, old, new and row-end flag held), FLUSH (held beat is the frame's last beat).
REQ-011 EMPTY + accept -> HOLD, no output.
REQ-012 HOLD + accept -> emit held beat next cycle, hold new beat; stay HOLD, or go FLUSH if the new beat is frame-last.
REQ-013 FLUSH + stall=0 -> emit held beat with frame_end=1 regardless of in_valid; a simultaneous accept captures the new beat (-> HOLD); otherwise -> EMPTY.
REQ-014 Outputs SHALL be registered; out_valid is a one-cycle pulse per emitted beat, held during stall; old_frame_d/new_frame_d equal the inputs of the emitted beat.
REQ-015 Output ordering SHALL equal input ordering; no beat dropped or duplicated.

Reset
REQ-016 rst_n=0 at a clock edge SHALL force EMPTY, counters 0, left carry 0, out_valid 0, frame_end 0, all data outputs 0; dominates stall.
REQ-017 Reset mid-frame SHALL discard the held beat; the next accepted beat is row 0, column 0.

Configuration
REQ-018 With DELTA_GAUSS_GAIN_EN defined, d SHALL be min(255, |new-old| << GAIN_SHIFT); without it, d = |new-old|; latency and handshake identical.

Structure
REQ-019 A shared package SHALL hold the FSM state enum, the BEATS_PER_ROW constant, and the pixel-width constant (8).
REQ-020 One sub-module, gauss_121_row, SHALL implement REQ-006..008 combinationally for one beat given L-carry, R-carry and row-start/row-end flags.

Verification
REQ-021 Uniform frame, all old=10, new=50, macro off -> every del_gauss byte 40; exactly IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT out_valid pulses; one frame_end.
REQ-022 Single impulse, row 3 pixel 17 |diff|=200 else 0 -> pixels 16,17,18 output 50,100,50; all else 0.
REQ-023 Row-edge impulse at pixel 0 diff=100 -> pixel 0 = 75, pixel 1 = 25; no leakage from the previous row's last pixel.
REQ-024 Random stall and in_valid gaps -> output stream bit-exact to the golden model; outputs constant while stall=1.
REQ-025 Last beat of frame followed by idle in_valid -> it emits one cycle later with frame_end=1; FSM returns to EMPTY.
REQ-026 Reset asserted mid-row, then a fresh frame -> first output treats beat 0 as row start; macro on, GAIN_SHIFT=2, diff 70 -> d=255 saturated.

Source files
------------

// File: rtl/delta_gauss_pkg.sv
// Shared types and constants for the delta_gauss motion-weight pipeline.
// Optional difference gain is enabled with DELTA_GAUSS_GAIN_EN.
package delta_gauss_pkg;

    localparam int PIX_W         = 8;
    localparam int DEF_PPB       = 16;
    localparam int DEF_IMAGE_DIM = 512;
    localparam int BEATS_PER_ROW = DEF_IMAGE_DIM / DEF_PPB;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_HOLD,
        ST_FLUSH
    } state_t;

    function automatic int beats_per_row(input int dim, input int ppb);
        return dim / ppb;
    endfunction

endpackage

// File: rtl/gauss_121_row.sv
// Horizontal [1 2 1] smoothing of one beat of difference pixels,
// with carries from neighbouring beats and edge replication at row ends.
module gauss_121_row
    import delta_gauss_pkg::*;
#(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT
) (
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic [PIX_W-1:0]      l_carry,
    input  logic [PIX_W-1:0]      r_carry,
    input  logic                  row_start,
    input  logic                  row_end,
    output logic [DATA_WIDTH-1:0] g_out
);

    for (genvar j = 0; j < PIXELS_PER_BEAT; j++) begin : g_pix
        logic [PIX_W-1:0] c;
        logic [PIX_W-1:0] l;
        logic [PIX_W-1:0] r;
        logic [PIX_W+1:0] s;

        assign c = d_in[PIX_W*j +: PIX_W];

        if (j == 0) begin : g_l_edge
            assign l = row_start ? c : l_carry;
        end else begin : g_l_in
            assign l = d_in[PIX_W*(j-1) +: PIX_W];
        end

        if (j == PIXELS_PER_BEAT - 1) begin : g_r_edge
            assign r = row_end ? c : r_carry;
        end else begin : g_r_in
            assign r = d_in[PIX_W*(j+1) +: PIX_W];
        end

        assign s = {2'b00, l} + {1'b0, c, 1'b0} + {2'b00, r}
                 + (PIX_W+2)'(2);
        assign g_out[PIX_W*j +: PIX_W] = PIX_W'(s >> 2);
    end

endmodule

// File: rtl/delta_gauss.sv
// Per-pixel |new-old| smoothed horizontally, one beat held for the right carry.
// Define DELTA_GAUSS_GAIN_EN to scale the difference by 2^GAIN_SHIFT (saturating).
module delta_gauss
    import delta_gauss_pkg::*;
#(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
    parameter int GAIN_SHIFT      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] old_frame,
    input  logic [DATA_WIDTH-1:0] new_frame,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] old_frame_d,
    output logic [DATA_WIDTH-1:0] new_frame_d,
    output logic [DATA_WIDTH-1:0] del_gauss,
    output logic                  frame_end
);

    localparam int BPR = beats_per_row(IMAGE_DIM, PIXELS_PER_BEAT);
    localparam int CW  = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int RW  = (IMAGE_DIM > 1) ? $clog2(IMAGE_DIM) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(BPR - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_DIM - 1);

`ifdef DELTA_GAUSS_GAIN_EN
    localparam int EFF_SHIFT = GAIN_SHIFT;
`else
    // difference gain is compiled out in this build
    localparam int EFF_SHIFT = 0 * GAIN_SHIFT;
`endif

    state_t                st_q, st_d;
    logic [DATA_WIDTH-1:0] hold_dif_q, hold_dif_d;
    logic [DATA_WIDTH-1:0] hold_old_q, hold_old_d;
    logic [DATA_WIDTH-1:0] hold_new_q, hold_new_d;
    logic                  hold_rs_q, hold_rs_d;
    logic                  hold_re_q, hold_re_d;
    logic [PIX_W-1:0]      lcarry_q, lcarry_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  ov_q, ov_d;
    logic                  fe_q, fe_d;
    logic [DATA_WIDTH-1:0] del_q, del_d;
    logic [DATA_WIDTH-1:0] oo_q, oo_d;
    logic [DATA_WIDTH-1:0] on_q, on_d;

    logic [DATA_WIDTH-1:0] cur_dif;
    logic [DATA_WIDTH-1:0] g_held;
    logic                  cur_rs;
    logic                  cur_re;
    logic                  cur_last;
    logic                  emit;
    logic                  fend;

    for (genvar j = 0; j < PIXELS_PER_BEAT; j++) begin : g_dif
        logic [PIX_W-1:0] a;
        logic [PIX_W-1:0] b;
        logic [PIX_W-1:0] ad;
        logic [15:0]      sh;

        assign a  = new_frame[PIX_W*j +: PIX_W];
        assign b  = old_frame[PIX_W*j +: PIX_W];
        assign ad = (a >= b) ? (a - b) : (b - a);
        assign sh = {8'd0, ad} << EFF_SHIFT;
        assign cur_dif[PIX_W*j +: PIX_W] = (sh > 16'd255) ? 8'hff : sh[7:0];
    end

    // right neighbour of the held beat is the first pixel of the arriving beat
    gauss_121_row #(
        .PIXELS_PER_BEAT(PIXELS_PER_BEAT),
        .DATA_WIDTH     (DATA_WIDTH)
    ) u_gauss (
        .d_in     (hold_dif_q),
        .l_carry  (lcarry_q),
        .r_carry  (cur_dif[PIX_W-1:0]),
        .row_start(hold_rs_q),
        .row_end  (hold_re_q),
        .g_out    (g_held)
    );

    assign cur_rs   = (col_q == '0);
    assign cur_re   = (col_q == COL_LAST);
    assign cur_last = cur_re && (row_q == ROW_LAST);

    always_comb begin
        st_d       = st_q;
        hold_dif_d = hold_dif_q;
        hold_old_d = hold_old_q;
        hold_new_d = hold_new_q;
        hold_rs_d  = hold_rs_q;
        hold_re_d  = hold_re_q;
        lcarry_d   = lcarry_q;
        col_d      = col_q;
        row_d      = row_q;
        ov_d       = ov_q;
        fe_d       = fe_q;
        del_d      = del_q;
        oo_d       = oo_q;
        on_d       = on_q;
        emit       = 1'b0;
        fend       = 1'b0;

        if (!stall) begin
            ov_d = 1'b0;
            fe_d = 1'b0;

            unique case (st_q)
                ST_EMPTY: begin
                    if (in_valid) st_d = cur_last ? ST_FLUSH : ST_HOLD;
                end
                ST_HOLD: begin
                    if (in_valid) begin
                        emit = 1'b1;
                        st_d = cur_last ? ST_FLUSH : ST_HOLD;
                    end
                end
                ST_FLUSH: begin
                    emit = 1'b1;
                    fend = 1'b1;
                    if (in_valid) st_d = cur_last ? ST_FLUSH : ST_HOLD;
                    else          st_d = ST_EMPTY;
                end
                default: st_d = ST_EMPTY;
            endcase

            if (emit) begin
                ov_d     = 1'b1;
                fe_d     = fend;
                del_d    = g_held;
                oo_d     = hold_old_q;
                on_d     = hold_new_q;
                lcarry_d = hold_dif_q[DATA_WIDTH-1 -: PIX_W];
            end

            if (in_valid) begin
                hold_dif_d = cur_dif;
                hold_old_d = old_frame;
                hold_new_d = new_frame;
                hold_rs_d  = cur_rs;
                hold_re_d  = cur_re;
                if (cur_re) begin
                    col_d = '0;
                    row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q       <= ST_EMPTY;
            hold_dif_q <= '0;
            hold_old_q <= '0;
            hold_new_q <= '0;
            hold_rs_q  <= 1'b0;
            hold_re_q  <= 1'b0;
            lcarry_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            ov_q       <= 1'b0;
            fe_q       <= 1'b0;
            del_q      <= '0;
            oo_q       <= '0;
            on_q       <= '0;
        end else begin
            st_q       <= st_d;
            hold_dif_q <= hold_dif_d;
            hold_old_q <= hold_old_d;
            hold_new_q <= hold_new_d;
            hold_rs_q  <= hold_rs_d;
            hold_re_q  <= hold_re_d;
            lcarry_q   <= lcarry_d;
            col_q      <= col_d;
            row_q      <= row_d;
            ov_q       <= ov_d;
            fe_q       <= fe_d;
            del_q      <= del_d;
            oo_q       <= oo_d;
            on_q       <= on_d;
        end
    end

    assign out_valid   = ov_q;
    assign frame_end   = fe_q;
    assign del_gauss   = del_q;
    assign old_frame_d = oo_q;
    assign new_frame_d = on_q;

endmodule
